ball_motion_engine: RTL and testbench

Parametrised multi-ball trajectory engine; successor to the single-ball mover. Holds NUM_BALLS independent ball states (fixed-point position, signed speed, active flag). Once per frame it updates every ball through one shared time-multiplexed datapath. Supports runtime spawn/kill of individual balls, wall clamping and a floor rebound; feeds the ball drawing/collision logic.

---
 rtl/ball_pkg.sv | 36 +++
 rtl/ball_step.sv | 59 +++++
 rtl/ball_motion_engine.sv | 110 +++++++++++
 tb/tb_ball_motion_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared types, widths and fixed-point helpers for the ball motion engine
package ball_pkg;

  localparam int FRAC_BITS = 6;
  localparam int PIX_W     = 11;
  localparam int SPD_W     = 12;
  localparam int POS_W     = PIX_W + FRAC_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } sweep_state_t;

  typedef struct packed {
    logic                    active;
    logic signed [POS_W-1:0] x;
    logic signed [POS_W-1:0] y;
    logic signed [SPD_W-1:0] vx;
    logic signed [SPD_W-1:0] vy;
  } ball_state_t;

  function automatic logic signed [POS_W-1:0] px_to_pos(input logic [PIX_W-1:0] px);
    return {1'b0, px, {FRAC_BITS{1'b0}}};
  endfunction

  // Positions are clamped to >= 0, so the sign bit is always clear here.
  function automatic logic [PIX_W-1:0] pos_to_px(input logic signed [POS_W-1:0] pos);
    return pos[FRAC_BITS +: PIX_W];
  endfunction

  function automatic logic signed [POS_W-1:0] spd_to_pos(input logic signed [SPD_W-1:0] spd);
    return {{(POS_W-SPD_W){spd[SPD_W-1]}}, spd};
  endfunction

endpackage

// File: rtl/ball_step.sv
// rtl/ball_step.sv - combinational single-ball update: move, gravity, wall clamp, floor rebound
// BALL_FIXED_REBOUND_EN selects a constant floor rebound speed instead of an elastic one.
module ball_step
  import ball_pkg::*;
#(
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int GRAVITY       = 1,
  parameter int REBOUND_SPEED = 448
) (
  input  ball_state_t cur,
  output ball_state_t nxt
);

  localparam logic signed [POS_W-1:0] XLIM     = POS_W'(X_MAX * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] YLIM     = POS_W'(Y_MAX * (2 ** FRAC_BITS));
  localparam logic signed [SPD_W:0]   GRAV     = (SPD_W+1)'(GRAVITY);
  localparam logic signed [SPD_W:0]   SPD_MAX  = (SPD_W+1)'(2 ** (SPD_W-1) - 1);
  localparam logic signed [SPD_W-1:0] FLOOR_VY = SPD_W'(-REBOUND_SPEED);
`ifdef BALL_FIXED_REBOUND_EN
  localparam bit FIXED_REBOUND = 1'b1;
`else
  localparam bit FIXED_REBOUND = 1'b0;
`endif

  logic signed [POS_W-1:0] nx;
  logic signed [POS_W-1:0] ny;
  logic signed [SPD_W:0]   vy_grav;
  logic signed [SPD_W-1:0] floor_vy;

  always_comb begin
    nxt      = cur;
    nx       = cur.x + spd_to_pos(cur.vx);
    ny       = cur.y + spd_to_pos(cur.vy);
    vy_grav  = {cur.vy[SPD_W-1], cur.vy} + GRAV;
    floor_vy = FIXED_REBOUND ? FLOOR_VY : -cur.vy;
    if (cur.active) begin
      nxt.x  = nx;
      nxt.y  = ny;
      nxt.vy = (vy_grav > SPD_MAX) ? SPD_MAX[SPD_W-1:0] : vy_grav[SPD_W-1:0];
      if (nx <= 0 && cur.vx < 0) begin
        nxt.x  = '0;
        nxt.vx = -cur.vx;
      end else if (nx >= XLIM && cur.vx > 0) begin
        nxt.x  = XLIM;
        nxt.vx = -cur.vx;
      end
      // A bounce replaces the gravity-updated speed for this frame.
      if (ny <= 0 && cur.vy < 0) begin
        nxt.y  = '0;
        nxt.vy = -cur.vy;
      end else if (ny >= YLIM && cur.vy > 0) begin
        nxt.y  = YLIM;
        nxt.vy = floor_vy;
      end
    end
  end

endmodule

// File: rtl/ball_motion_engine.sv
// rtl/ball_motion_engine.sv - multi-ball trajectory engine sweeping all slots once per frame
// Floor rebound mode is chosen inside ball_step by BALL_FIXED_REBOUND_EN.
module ball_motion_engine
  import ball_pkg::*;
#(
  parameter int  NUM_BALLS     = 4,
  parameter int  X_MAX         = 639,
  parameter int  Y_MAX         = 479,
  parameter int  GRAVITY       = 1,
  parameter int  REBOUND_SPEED = 448,
  localparam int IDX_W         = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              startOfFrame,
  input  logic                              spawnReq,
  input  logic [IDX_W-1:0]                  spawnIdx,
  input  logic [PIX_W-1:0]                  spawnX,
  input  logic [PIX_W-1:0]                  spawnY,
  input  logic signed [SPD_W-1:0]           spawnXspeed,
  input  logic signed [SPD_W-1:0]           spawnYspeed,
  input  logic                              killReq,
  input  logic [IDX_W-1:0]                  killIdx,
  output logic [NUM_BALLS-1:0]              active,
  output logic [NUM_BALLS-1:0][PIX_W-1:0]   topLeftX,
  output logic [NUM_BALLS-1:0][PIX_W-1:0]   topLeftY,
  output logic                              busy,
  output logic                              frameDone,
  output logic                              overrun
);

  sweep_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overrun_q, overrun_d;
  ball_state_t      balls_q [NUM_BALLS];
  ball_state_t      balls_d [NUM_BALLS];
  ball_state_t      step_in, step_out;

  assign step_in = balls_q[idx_q];

  ball_step #(
    .X_MAX         (X_MAX),
    .Y_MAX         (Y_MAX),
    .GRAVITY       (GRAVITY),
    .REBOUND_SPEED (REBOUND_SPEED)
  ) u_step (
    .cur (step_in),
    .nxt (step_out)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q | (startOfFrame && state_q != ST_IDLE);
    balls_d   = balls_q;
    case (state_q)
      ST_IDLE: begin
        if (startOfFrame) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        balls_d[idx_q] = step_out;
        if (idx_q == IDX_W'(NUM_BALLS - 1)) state_d = ST_DONE;
        else                                idx_d   = idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Host requests are applied after the sweep write so they win; kill goes last so it wins over spawn.
    if (spawnReq && int'(spawnIdx) < NUM_BALLS) begin
      balls_d[spawnIdx].active = 1'b1;
      balls_d[spawnIdx].x      = px_to_pos(spawnX);
      balls_d[spawnIdx].y      = px_to_pos(spawnY);
      balls_d[spawnIdx].vx     = spawnXspeed;
      balls_d[spawnIdx].vy     = spawnYspeed;
    end
    if (killReq && int'(killIdx) < NUM_BALLS) begin
      balls_d[killIdx]        = balls_q[killIdx];
      balls_d[killIdx].active = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) balls_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NUM_BALLS; i++) balls_q[i] <= balls_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      active[i]   = balls_q[i].active;
      topLeftX[i] = pos_to_px(balls_q[i].x);
      topLeftY[i] = pos_to_px(balls_q[i].y);
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign frameDone = (state_q == ST_DONE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// tb/tb_ball_motion_engine.sv - directed self-checking bench for ball_motion_engine
module tb_ball_motion_engine;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              spawnReq;
  logic [1:0]        spawnIdx;
  logic [10:0]       spawnX, spawnY;
  logic signed [11:0] spawnXspeed, spawnYspeed;
  logic              killReq;
  logic [1:0]        killIdx;
  logic [3:0]        active;
  logic [3:0][10:0]  topLeftX, topLeftY;
  logic              busy, frameDone, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_motion_engine dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .spawnReq     (spawnReq),
    .spawnIdx     (spawnIdx),
    .spawnX       (spawnX),
    .spawnY       (spawnY),
    .spawnXspeed  (spawnXspeed),
    .spawnYspeed  (spawnYspeed),
    .killReq      (killReq),
    .killIdx      (killIdx),
    .active       (active),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .busy         (busy),
    .frameDone    (frameDone),
    .overrun      (overrun)
  );

  task automatic spawn(input int idx, input int x, input int y, input int vx, input int vy);
    @(posedge clk); #1;
    spawnReq = 1'b1; spawnIdx = 2'(idx);
    spawnX = 11'(x); spawnY = 11'(y);
    spawnXspeed = 12'(vx); spawnYspeed = 12'(vy);
    @(posedge clk); #1;
    spawnReq = 1'b0;
  endtask

  // Leaves the bench in cycle T+1 of the sweep.
  task automatic start_frame;
    @(posedge clk); #1;
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
  endtask

  // cyc is the offset from T of the cycle in which frameDone is seen.
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (frameDone !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_frame(output int cyc);
    start_frame();
    wait_done(1, cyc);
  endtask

  task automatic test_reset;
    checks++; if (active !== 4'b0) begin errors++; $display("FAIL reset_active got %b exp 0000", active); end
    checks++; if (topLeftX !== '0) begin errors++; $display("FAIL reset_x got %h exp 0", topLeftX); end
    checks++; if (topLeftY !== '0) begin errors++; $display("FAIL reset_y got %h exp 0", topLeftY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frameDone); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_basic_move;
    int cyc;
    spawn(0, 100, 100, 64, 0);
    checks++; if (active !== 4'b0001) begin errors++; $display("FAIL spawn_active got %b exp 0001", active); end
    checks++; if (topLeftX[0] !== 11'd100) begin errors++; $display("FAIL spawn_x got %0d exp 100", topLeftX[0]); end
    start_frame();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy got %b exp 1", busy); end
    wait_done(1, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL done_latency got %0d exp 5", cyc); end
    checks++; if (topLeftX[0] !== 11'd101) begin errors++; $display("FAIL move_x1 got %0d exp 101", topLeftX[0]); end
    checks++; if (topLeftY[0] !== 11'd100) begin errors++; $display("FAIL move_y1 got %0d exp 100", topLeftY[0]); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    run_frame(cyc);
    checks++; if (topLeftX[0] !== 11'd102) begin errors++; $display("FAIL move_x2 got %0d exp 102", topLeftX[0]); end
    checks++; if (topLeftY[0] !== 11'd100) begin errors++; $display("FAIL move_y2 got %0d exp 100", topLeftY[0]); end
  endtask

  task automatic test_right_wall;
    int cyc;
    spawn(1, 639, 200, 64, 0);
    run_frame(cyc);
    checks++; if (topLeftX[1] !== 11'd639) begin errors++; $display("FAIL rwall_x1 got %0d exp 639", topLeftX[1]); end
    checks++; if (topLeftX[0] !== 11'd103) begin errors++; $display("FAIL rwall_s0_x got %0d exp 103", topLeftX[0]); end
    run_frame(cyc);
    checks++; if (topLeftX[1] !== 11'd638) begin errors++; $display("FAIL rwall_x2 got %0d exp 638", topLeftX[1]); end
    checks++; if (topLeftX[0] !== 11'd104) begin errors++; $display("FAIL rwall_s0_x2 got %0d exp 104", topLeftX[0]); end
  endtask

  task automatic test_floor;
    int cyc;
    logic [10:0] exp_y2;
`ifdef BALL_FIXED_REBOUND_EN
    exp_y2 = 11'd472;
`else
    exp_y2 = 11'd478;
`endif
    spawn(3, 10, 479, 0, 64);
    run_frame(cyc);
    checks++; if (topLeftY[3] !== 11'd479) begin errors++; $display("FAIL floor_y1 got %0d exp 479", topLeftY[3]); end
    run_frame(cyc);
    checks++; if (topLeftY[3] !== exp_y2) begin errors++; $display("FAIL floor_y2 got %0d exp %0d", topLeftY[3], exp_y2); end
    checks++; if (topLeftX[3] !== 11'd10) begin errors++; $display("FAIL floor_x got %0d exp 10", topLeftX[3]); end
  endtask

  task automatic test_left_wall;
    int cyc;
    spawn(2, 0, 50, -64, 0);
    run_frame(cyc);
    checks++; if (topLeftX[2] !== 11'd0) begin errors++; $display("FAIL lwall_x1 got %0d exp 0", topLeftX[2]); end
    run_frame(cyc);
    checks++; if (topLeftX[2] !== 11'd1) begin errors++; $display("FAIL lwall_x2 got %0d exp 1", topLeftX[2]); end
  endtask

  task automatic test_kill_mid_sweep;
    int cyc;
    spawn(2, 300, 300, 64, 64);
    spawn(0, 50, 60, -64, 0);
    start_frame();
    @(posedge clk); #1;
    @(posedge clk); #1;
    killReq = 1'b1; killIdx = 2'd2;
    @(posedge clk); #1;
    killReq = 1'b0;
    wait_done(4, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL kill_latency got %0d exp 5", cyc); end
    checks++; if (active !== 4'b1011) begin errors++; $display("FAIL kill_active got %b exp 1011", active); end
    checks++; if (topLeftX[2] !== 11'd300) begin errors++; $display("FAIL kill_x got %0d exp 300", topLeftX[2]); end
    checks++; if (topLeftY[2] !== 11'd300) begin errors++; $display("FAIL kill_y got %0d exp 300", topLeftY[2]); end
    checks++; if (topLeftX[0] !== 11'd49) begin errors++; $display("FAIL kill_s0_x got %0d exp 49", topLeftX[0]); end
    checks++; if (topLeftY[0] !== 11'd60) begin errors++; $display("FAIL kill_s0_y got %0d exp 60", topLeftY[0]); end
    @(posedge clk); #1;
    spawnReq = 1'b1; spawnIdx = 2'd2; spawnX = 11'd5; spawnY = 11'd5;
    spawnXspeed = 12'sd0; spawnYspeed = 12'sd0;
    killReq = 1'b1; killIdx = 2'd2;
    @(posedge clk); #1;
    spawnReq = 1'b0; killReq = 1'b0;
    checks++; if (active[2] !== 1'b0) begin errors++; $display("FAIL spawnkill_active got %b exp 0", active[2]); end
    checks++; if (topLeftX[2] !== 11'd300) begin errors++; $display("FAIL spawnkill_x got %0d exp 300", topLeftX[2]); end
  endtask

  task automatic test_overrun;
    int cyc;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre got %b exp 0", overrun); end
    start_frame();
    @(posedge clk); #1;
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    wait_done(3, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL overrun_latency got %0d exp 5", cyc); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_idle got %b exp 0", busy); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_reset_mid_sweep;
    int cyc;
    start_frame();
    @(posedge clk); #1;
    resetN = 1'b0;
    #1;
    checks++; if (active !== 4'b0) begin errors++; $display("FAIL midrst_active got %b exp 0000", active); end
    checks++; if (topLeftX !== '0) begin errors++; $display("FAIL midrst_x got %h exp 0", topLeftX); end
    checks++; if (topLeftY !== '0) begin errors++; $display("FAIL midrst_y got %h exp 0", topLeftY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b exp 0", overrun); end
    @(posedge clk); #1;
    resetN = 1'b1;
    run_frame(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL postrst_latency got %0d exp 5", cyc); end
    checks++; if (topLeftX[0] !== 11'd0) begin errors++; $display("FAIL postrst_x got %0d exp 0", topLeftX[0]); end
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; spawnReq = 1'b0; spawnIdx = '0;
    spawnX = '0; spawnY = '0; spawnXspeed = '0; spawnYspeed = '0;
    killReq = 1'b0; killIdx = '0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_move();
    test_right_wall();
    test_floor();
    test_left_wall();
    test_kill_mid_sweep();
    test_overrun();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
